// File: rtl/axp_mem_pkg.sv
// Shared opcode, mask, FSM and bus-payload definitions for the axp memory stage.
package axp_mem_pkg;

   localparam int unsigned DATA_W = 64;
   localparam int unsigned BYTES  = 8;
   localparam int unsigned OP_W   = 6;

   localparam logic [OP_W-1:0] OP_LDBU  = 6'h0A;
   localparam logic [OP_W-1:0] OP_LDQ_U = 6'h0B;
   localparam logic [OP_W-1:0] OP_LDWU  = 6'h0C;
   localparam logic [OP_W-1:0] OP_STW   = 6'h0D;
   localparam logic [OP_W-1:0] OP_STB   = 6'h0E;
   localparam logic [OP_W-1:0] OP_STQ_U = 6'h0F;
   localparam logic [OP_W-1:0] OP_LDL   = 6'h28;
   localparam logic [OP_W-1:0] OP_LDQ   = 6'h29;
   localparam logic [OP_W-1:0] OP_LDL_L = 6'h2A;
   localparam logic [OP_W-1:0] OP_LDQ_L = 6'h2B;
   localparam logic [OP_W-1:0] OP_STL   = 6'h2C;
   localparam logic [OP_W-1:0] OP_STQ   = 6'h2D;
   localparam logic [OP_W-1:0] OP_STL_C = 6'h2E;
   localparam logic [OP_W-1:0] OP_STQ_C = 6'h2F;

   localparam logic [BYTES-1:0] MASK_B = 8'h01;
   localparam logic [BYTES-1:0] MASK_W = 8'h03;
   localparam logic [BYTES-1:0] MASK_L = 8'h0F;
   localparam logic [BYTES-1:0] MASK_Q = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_RESP
   } lsu_state_e;

   typedef struct packed {
      logic store;
      logic unal;
      logic ldl;
      logic stc;
      logic sext;
   } op_dec_t;

   typedef struct packed {
      logic              we;
      logic [DATA_W-1:0] addr;
      logic [BYTES-1:0]  wmask;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

   function automatic op_dec_t decode_op(input logic [OP_W-1:0] op);
      op_dec_t d;
      d.store = op[2] & (op[5] | op[1] | op[0]);
      d.unal  = (op == OP_LDQ_U) || (op == OP_STQ_U);
      d.ldl   = (op == OP_LDL_L) || (op == OP_LDQ_L);
      d.stc   = (op == OP_STL_C) || (op == OP_STQ_C);
      d.sext  = (op == OP_LDL)   || (op == OP_LDL_L);
      return d;
   endfunction

   function automatic logic align_fault(input logic [BYTES-1:0] mask,
                                        input logic [2:0]       off,
                                        input logic             unal);
      return ((mask == MASK_W) && off[0])
          || ((mask == MASK_L) && (off[1:0] != 2'b00))
          || ((mask == MASK_Q) && !unal && (off != 3'b000));
   endfunction

endpackage

// File: rtl/axp_lsu_if.sv
// Upstream request, memory bus and writeback signals of the axp load/store stage.
interface axp_lsu_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_cmd;
   logic [63:0] in_addr;
   logic [7:0]  in_mask;
   logic [63:0] in_data;

   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [7:0]  mem_wmask;
   logic [63:0] mem_wdata;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;

   logic        out_valid;
   logic        out_ready;
   logic        out_wen;
   logic [63:0] out_data;
   logic        out_fault;

   // LSU side
   modport slave (
      input  in_valid, in_cmd, in_addr, in_mask, in_data,
      output in_ready,
      output mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
      input  mem_ready, mem_rvalid, mem_rdata,
      output out_valid, out_wen, out_data, out_fault,
      input  out_ready
   );

   // Pipeline / memory / writeback side
   modport master (
      output in_valid, in_cmd, in_addr, in_mask, in_data,
      input  in_ready,
      input  mem_valid, mem_we, mem_addr, mem_wmask, mem_wdata,
      output mem_ready, mem_rvalid, mem_rdata,
      input  out_valid, out_wen, out_data, out_fault,
      output out_ready
   );
endinterface

// File: rtl/axp_lane.sv
// Byte-lane placement for stores and lane extract / zero-sign extension for loads.
module axp_lane
   import axp_mem_pkg::*;
(
   input  logic [2:0]        st_off_i,
   input  logic [BYTES-1:0]  st_mask_i,
   input  logic [DATA_W-1:0] st_data_i,
   output logic [BYTES-1:0]  st_wmask_c_o,
   output logic [DATA_W-1:0] st_wdata_c_o,
   input  logic [2:0]        ld_off_i,
   input  logic [BYTES-1:0]  ld_mask_i,
   input  logic              ld_sext_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic [DATA_W-1:0] ld_res_c_o
);

   logic [DATA_W-1:0] ld_shift;
   logic [DATA_W-1:0] ld_bmask;
   logic [DATA_W-1:0] ld_masked;

   assign st_wmask_c_o = st_mask_i << st_off_i;
   assign st_wdata_c_o = st_data_i << {st_off_i, 3'b000};

   // Bring the addressed bytes down to lane 0, then trim to the access size.
   always_comb begin
      ld_shift = ld_data_i >> {ld_off_i, 3'b000};
      ld_bmask = '0;
      for (int unsigned i = 0; i < BYTES; i++) begin
         ld_bmask[i*8 +: 8] = {8{ld_mask_i[i]}};
      end
      ld_masked = ld_shift & ld_bmask;
   end

   assign ld_res_c_o = ld_sext_i ? {{32{ld_masked[31]}}, ld_masked[31:0]} : ld_masked;

endmodule

// File: rtl/axp_lsu.sv
// Single-outstanding load/store stage: alignment check, 64-bit bus access, writeback.
// Optional LDx_L/STx_C lock tracking is built when AXP_LOCK_EN is defined.
module axp_lsu
   import axp_mem_pkg::*;
#(
   parameter int unsigned LOCK_SHIFT = 4
) (
   input  logic       clock,
   input  logic       reset,
   axp_lsu_if.slave   bus_if
);

   if (LOCK_SHIFT > 63) begin : g_bad_lock_shift
      $error("LOCK_SHIFT must be below 64");
   end

   lsu_state_e        state_q, state_d;
   logic              in_ready_q, in_ready_d;
   logic              mem_valid_q, mem_valid_d;
   mem_req_t          req_q, req_d;
   logic              out_valid_q, out_valid_d;
   logic              out_wen_q, out_wen_d;
   logic              out_fault_q, out_fault_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [2:0]        off_q, off_d;
   logic [BYTES-1:0]  mask_q, mask_d;
   logic              sext_q, sext_d;
   logic              store_q, store_d;
   logic              stc_q, stc_d;

   op_dec_t           dec_c;
   logic [2:0]        in_off_c;
   logic              in_fault_c;
   logic              accept_c;
   logic              stc_ok_c;
   logic [BYTES-1:0]  st_wmask_c;
   logic [DATA_W-1:0] st_wdata_c;
   logic [DATA_W-1:0] ld_res_c;
   logic              unused_cmd_c;

   assign dec_c        = decode_op(bus_if.in_cmd[31:26]);
   assign in_off_c     = dec_c.unal ? 3'b000 : bus_if.in_addr[2:0];
   assign in_fault_c   = align_fault(bus_if.in_mask, in_off_c, dec_c.unal);
   assign accept_c     = (state_q == ST_IDLE) && bus_if.in_valid;
   assign unused_cmd_c = ^bus_if.in_cmd[25:0];

   axp_lane u_lane (
      .st_off_i     (in_off_c),
      .st_mask_i    (bus_if.in_mask),
      .st_data_i    (bus_if.in_data),
      .st_wmask_c_o (st_wmask_c),
      .st_wdata_c_o (st_wdata_c),
      .ld_off_i     (off_q),
      .ld_mask_i    (mask_q),
      .ld_sext_i    (sext_q),
      .ld_data_i    (bus_if.mem_rdata),
      .ld_res_c_o   (ld_res_c)
   );

`ifdef AXP_LOCK_EN
   localparam int unsigned TAG_W = DATA_W - LOCK_SHIFT;

   logic             lock_q, lock_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             gran_hit_c;

   assign gran_hit_c = (tag_q == bus_if.in_addr[DATA_W-1:LOCK_SHIFT]);
   assign stc_ok_c   = lock_q && gran_hit_c;

   // Lock flag/tag update on request acceptance.
   always_comb begin
      lock_d = lock_q;
      tag_d  = tag_q;
      if (accept_c && !in_fault_c) begin
         if (dec_c.ldl) begin
            lock_d = 1'b1;
            tag_d  = bus_if.in_addr[DATA_W-1:LOCK_SHIFT];
         end else if (dec_c.store && gran_hit_c) begin
            lock_d = 1'b0;
         end
      end
      if (accept_c && dec_c.stc) begin
         lock_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         lock_q <= 1'b0;
         tag_q  <= '0;
      end else begin
         lock_q <= lock_d;
         tag_q  <= tag_d;
      end
   end
`else
   logic unused_ldl_c;

   assign stc_ok_c     = 1'b1;
   assign unused_ldl_c = dec_c.ldl;
`endif

   // Next state and registered outputs; every output is a function of the next state.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      mem_valid_d = mem_valid_q;
      req_d       = req_q;
      out_valid_d = out_valid_q;
      out_wen_d   = out_wen_q;
      out_fault_d = out_fault_q;
      out_data_d  = out_data_q;
      off_d       = off_q;
      mask_d      = mask_q;
      sext_d      = sext_q;
      store_d     = store_q;
      stc_d       = stc_q;

      case (state_q)
         ST_IDLE: begin
            if (bus_if.in_valid) begin
               in_ready_d  = 1'b0;
               off_d       = in_off_c;
               mask_d      = bus_if.in_mask;
               sext_d      = dec_c.sext;
               store_d     = dec_c.store;
               stc_d       = dec_c.stc;
               req_d.we    = dec_c.store;
               req_d.addr  = {bus_if.in_addr[DATA_W-1:3], 3'b000};
               req_d.wmask = dec_c.store ? st_wmask_c : '0;
               req_d.wdata = dec_c.store ? st_wdata_c : '0;
               if (in_fault_c) begin
                  state_d     = ST_RESP;
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b1;
                  out_wen_d   = 1'b0;
                  out_data_d  = '0;
               end else if (dec_c.stc && !stc_ok_c) begin
                  // Failed store-conditional never touches the bus.
                  state_d     = ST_RESP;
                  out_valid_d = 1'b1;
                  out_fault_d = 1'b0;
                  out_wen_d   = 1'b1;
                  out_data_d  = '0;
               end else begin
                  state_d     = ST_REQ;
                  mem_valid_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (bus_if.mem_ready) begin
               state_d     = ST_WAIT;
               mem_valid_d = 1'b0;
            end
         end
         ST_WAIT: begin
            if (bus_if.mem_rvalid) begin
               state_d     = ST_RESP;
               out_valid_d = 1'b1;
               out_fault_d = 1'b0;
               if (store_q) begin
                  out_wen_d  = stc_q;
                  out_data_d = DATA_W'(stc_q);
               end else begin
                  out_wen_d  = 1'b1;
                  out_data_d = ld_res_c;
               end
            end
         end
         ST_RESP: begin
            if (bus_if.out_ready) begin
               state_d     = ST_IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_wen_d   = 1'b0;
               out_fault_d = 1'b0;
               out_data_d  = '0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            in_ready_d  = 1'b1;
            mem_valid_d = 1'b0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         in_ready_q  <= 1'b1;
         mem_valid_q <= 1'b0;
         req_q       <= '0;
         out_valid_q <= 1'b0;
         out_wen_q   <= 1'b0;
         out_fault_q <= 1'b0;
         out_data_q  <= '0;
         off_q       <= '0;
         mask_q      <= '0;
         sext_q      <= 1'b0;
         store_q     <= 1'b0;
         stc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         mem_valid_q <= mem_valid_d;
         req_q       <= req_d;
         out_valid_q <= out_valid_d;
         out_wen_q   <= out_wen_d;
         out_fault_q <= out_fault_d;
         out_data_q  <= out_data_d;
         off_q       <= off_d;
         mask_q      <= mask_d;
         sext_q      <= sext_d;
         store_q     <= store_d;
         stc_q       <= stc_d;
      end
   end

   assign bus_if.in_ready  = in_ready_q;
   assign bus_if.mem_valid = mem_valid_q;
   assign bus_if.mem_we    = req_q.we;
   assign bus_if.mem_addr  = req_q.addr;
   assign bus_if.mem_wmask = req_q.wmask;
   assign bus_if.mem_wdata = req_q.wdata;
   assign bus_if.out_valid = out_valid_q;
   assign bus_if.out_wen   = out_wen_q;
   assign bus_if.out_fault = out_fault_q;
   assign bus_if.out_data  = out_data_q;

endmodule

// File: doc/axp_lsu.md
Name: axp_lsu

Overview:
Memory-access stage directly downstream of the opcode 08-0F/2x address/mask calculation. Takes one effective address, byte-size mask and store operand per instruction and checks natural alignment. Drives a single-outstanding 64-bit aligned memory bus, then returns the lane-aligned, zero/sign-extended load result (or STx_C status) for register writeback. Valid/ready handshakes on both the upstream and writeback sides.

Parameters:
LOCK_SHIFT, 4, log2 of the lock granule in bytes; LDx_L/STx_C compare addr[63:LOCK_SHIFT].

Ports:
clock  input  1  sole clock
reset  input  1  synchronous, active-high
in_valid  input  1  request present
in_ready  output  1  stage accepts request
in_cmd  input  32  instruction word; op = in_cmd[31:26]
in_addr  input  64  effective address
in_mask  input  8  size mask: 01 byte, 03 word, 0F long, FF quad
in_data  input  64  store operand (Ra), right-justified
mem_valid  output  1  bus request
mem_ready  input  1  bus accepts request
mem_we  output  1  1 = write
mem_addr  output  64  quadword address, bits [2:0] = 0
mem_wmask  output  8  byte enables
mem_wdata  output  64  lane-placed store data
mem_rvalid  input  1  response (loads and stores)
mem_rdata  input  64  read quadword
out_valid  output  1  result present
out_ready  input  1  writeback accepts
out_wen  output  1  write Ra
out_data  output  64  load value / STx_C status
out_fault  output  1  alignment fault, no access performed

Behaviour:
- Classification: store = op[2] & (op[5] | op[1] | op[0]); unaligned-quad (_U) = op 0B/0F; locked = op 2A/2B (LDx_L), 2E/2F (STx_C); sext32 = op 28/2A.
- Byte offset o = in_addr[2:0], forced to 0 for _U ops; mem_addr = {in_addr[63:3],3'b0}.
- Fault: (mask 03 & o[0]) | (mask 0F & o[1:0]!=0) | (mask FF & !_U & o!=0).
- FSM IDLE, REQ, WAIT, RESP. in_ready = (state==IDLE).
- IDLE: on in_valid, latch request. Fault -> RESP with out_fault=1, out_wen=0. Otherwise -> REQ.
- REQ: mem_valid=1 with mem_we/addr/wmask/wdata stable until mem_ready. Then -> WAIT.
- WAIT: on mem_rvalid -> RESP; load data is latched that cycle. mem_rvalid in other states is ignored.
- RESP: out_valid=1 and held stable until out_ready -> IDLE. A new request is never accepted in the same cycle as out_ready (one-cycle bubble).
- Store lanes: mem_wmask = mask << o; mem_wdata = in_data << 8*o. Loads use mem_wmask = 0.
- Load result: r = mem_rdata >> 8*o, AND byte-mask, then bits [63:32] = r[31] when sext32. LDBU/LDWU zero-extend. Loads: out_wen=1.
- Plain stores: out_wen=0, out_data=0.
- Reset (any state, including mid-transaction): state IDLE; all outputs 0 except in_ready=1; lock cleared. The bus shares the reset, so the abandoned transaction needs no drain.

Optional Feature:
AXP_LOCK_EN
- Defined: a lock flag and lock tag are held.
  - LDx_L sets the flag and records addr[63:LOCK_SHIFT].
  - STx_C with flag set and tag match performs the store and returns out_data=1.
  - STx_C on mismatch skips the bus (IDLE->RESP) and returns 0.
  - Every STx_C clears the flag.
  - Any plain store whose granule matches the tag clears the flag.
- Undefined: no lock state. LDx_L behaves as LDL/LDQ. STx_C always stores and returns 1.
- In both cases STx_C has out_wen=1.

Decomposition:
- Package axp_mem_pkg holds the opcode constants (LDBU 0A, LDQ_U 0B, LDWU 0C, STW 0D, STB 0E, STQ_U 0F, LDL 28 … STQ_C 2F), the FSM state enum and mask constants.
- Sub-module axp_lane (combinational) does store lane placement and load extract/extend; it is shared with future unaligned-access logic.

Test Plan:
- LDL addr 0x1004, rdata 0x80000000_11112222 -> out_data 0xFFFFFFFF_80000000, wen=1, fault=0.
- LDBU addr 0x2007, rdata 0xAB00…00 -> out_data 0xAB; LDWU addr 0x2003 (mask 03) -> out_fault=1, no mem_valid.
- STB addr 0x3005, in_data 0x5A -> mem_wmask 0x20, mem_wdata 0x00005A00_00000000, mem_addr 0x3000, out_wen=0.
- LDQ_U addr 0x4007 -> mem_addr 0x4000, out_data = rdata unshifted. mem_ready held low 5 cycles -> request held stable. out_ready low 3 cycles -> out_* stable.
- AXP_LOCK_EN: LDQ_L 0x5008; STQ_C 0x500C -> store issued, out_data 1; repeat STQ_C -> no bus access, out_data 0.
- Reset asserted during WAIT -> next cycle in_ready=1, mem_valid=0, out_valid=0; a subsequent LDQ completes normally.
